// File: rtl/pio_input_conditioner_pkg.sv
// Shared constants, command decode and button-word packing for the PIO input
// conditioner. Every bit position of the host command word and of the button
// status word is defined here so that the RTL and any checker agree on one map.
// Optional feature macro: PIO_COND_IRQ_EN (adds the irq output).
package pio_cond_pkg;

  localparam int WORD_W = 32;

  // Host command word (cmd_word) fields
  localparam int CMD_STROBE_BIT  = 31;  // toggled by the host to issue a command
  localparam int CMD_CLR_LSB     = 4;   // sticky-flag clear mask, bits 7:4
  localparam int CMD_CLR_W       = 4;
  localparam int CMD_CNT_CLR_BIT = 8;   // clear the press counter
  localparam int CMD_IRQ_LSB     = 9;   // irq enable mask, bits 12:9
  localparam int CMD_IRQ_W       = 4;

  // Button status word (button_word) fields
  localparam int BTN_LEVEL_LSB  = 0;    // accepted key levels, bits 3:0
  localparam int BTN_STICKY_LSB = 4;    // sticky press flags, bits 7:4
  localparam int BTN_FIELD_W    = 4;
  localparam int BTN_ACK_BIT    = 15;   // echo of the last accepted strobe level
  localparam int BTN_CNT_LSB    = 16;   // press counter, bits 23:16
  localparam int BTN_CNT_W      = 8;

  // Decoded view of one command word against the registered strobe level
  typedef struct packed {
    logic                 strobe;    // strobe bit differs from its registered copy
    logic                 level;     // current strobe bit value
    logic [CMD_CLR_W-1:0] clr_mask;
    logic                 cnt_clr;
    logic [CMD_IRQ_W-1:0] irq_mask;
  } cmd_t;

  // Split a command word into its fields; a strobe is a change of bit 31
  function automatic cmd_t decode_cmd(input logic [WORD_W-1:0] word,
                                      input logic              prev_level);
    cmd_t c;
    c.level    = word[CMD_STROBE_BIT];
    c.strobe   = word[CMD_STROBE_BIT] ^ prev_level;
    c.clr_mask = word[CMD_CLR_LSB +: CMD_CLR_W];
    c.cnt_clr  = word[CMD_CNT_CLR_BIT];
    c.irq_mask = word[CMD_IRQ_LSB +: CMD_IRQ_W];
    return c;
  endfunction

  // Assemble the button status word; all bits outside the named fields are 0
  function automatic logic [WORD_W-1:0] pack_button_word(
      input logic [BTN_FIELD_W-1:0] level,
      input logic [BTN_FIELD_W-1:0] sticky,
      input logic                   ack,
      input logic [BTN_CNT_W-1:0]   cnt);
    logic [WORD_W-1:0] w;
    w = '0;
    w[BTN_LEVEL_LSB  +: BTN_FIELD_W] = level;
    w[BTN_STICKY_LSB +: BTN_FIELD_W] = sticky;
    w[BTN_ACK_BIT]                   = ack;
    w[BTN_CNT_LSB    +: BTN_CNT_W]   = cnt;
    return w;
  endfunction

endpackage

// File: rtl/pio_input_conditioner_if.sv
// Host-side bus of the PIO input conditioner: the command word written by the
// host PIO and the two status words read back by it.
// Handshake: the host issues a command by toggling cmd_word[31] (one command
// per change, no level sensitivity); the conditioner acknowledges by echoing
// that bit in button_word[15] one cycle after the change.
// Optional feature macro: PIO_COND_IRQ_EN (adds irq to the bus).
interface pio_input_conditioner_if;

  logic [31:0] cmd_word;
  logic [31:0] switch_word;
  logic [31:0] button_word;

`ifdef PIO_COND_IRQ_EN
  logic        irq;

  modport master (output cmd_word, input switch_word, input button_word, input irq);
  modport slave  (input cmd_word, output switch_word, output button_word, output irq);
`else
  modport master (output cmd_word, input switch_word, input button_word);
  modport slave  (input cmd_word, output switch_word, output button_word);
`endif

endinterface

// File: rtl/pio_input_conditioner_debounce_bit.sv
// One conditioned input bit: 2-flop synchronizer, stability counter and the
// accepted level. The accepted level only moves after the synchronized input
// has disagreed with it for DEBOUNCE_CYCLES consecutive cycles.
module debounce_bit #(
  parameter int   DEBOUNCE_CYCLES = 50000,
  parameter logic RESET_LEVEL     = 1'b0
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic level_o
);

  // Counter only needs to hold 0..DEBOUNCE_CYCLES-1
  localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q;
  logic             sync2_q;
  logic             level_q;
  logic             level_d;
  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Two-stage synchronizer; loads the idle level of the input during reset
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      sync1_q <= RESET_LEVEL;
      sync2_q <= RESET_LEVEL;
    end else begin
      sync1_q <= raw_i;
      sync2_q <= sync1_q;
    end
  end

  // Count cycles of disagreement; flip the level on the last one and restart
  always_comb begin
    level_d = level_q;
    cnt_d   = '0;
    if (sync2_q != level_q) begin
      if (cnt_q == CNT_LAST) begin
        level_d = sync2_q;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  // Accepted level and counter; reset discards any partial count
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      level_q <= RESET_LEVEL;
      cnt_q   <= '0;
    end else begin
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level_o = level_q;

endmodule

// File: rtl/pio_input_conditioner.sv
// PIO input conditioner: debounces slide switches and push buttons, and keeps
// sticky press flags plus a press counter that the host clears by toggling
// cmd_word[31]. All host-visible outputs come straight from registers.
// Optional feature macro: PIO_COND_IRQ_EN (adds a registered irq output that
// ORs the sticky flags enabled by cmd_word[12:9]).
module pio_input_conditioner
  import pio_cond_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 50000,
  parameter int SW_WIDTH        = 18,
  parameter int KEY_WIDTH       = 4
) (
  input  logic                     clk_clk,
  input  logic                     reset_reset_n,
  input  logic [SW_WIDTH-1:0]      sw_raw,
  input  logic [KEY_WIDTH-1:0]     key_raw_n,
  pio_input_conditioner_if.slave   host
);

  // Debounced levels straight out of the per-bit conditioners
  logic [SW_WIDTH-1:0]  sw_level;
  logic [KEY_WIDTH-1:0] key_level_n;
  logic [KEY_WIDTH-1:0] key_level;

  // Output registers and their next-state values
  logic [SW_WIDTH-1:0]  sw_out_q,   sw_out_d;
  logic [KEY_WIDTH-1:0] key_out_q,  key_out_d;
  logic [KEY_WIDTH-1:0] sticky_q,   sticky_d;
  logic [BTN_CNT_W-1:0] cnt_q,      cnt_d;
  logic                 cmd_prev_q, cmd_prev_d;

  logic [KEY_WIDTH-1:0] press_edge;
  logic [KEY_WIDTH-1:0] clr_mask;
  logic                 any_press;
  cmd_t                 cmd;

  // Only some command bits are decoded in a given build
  logic unused_cmd_bits;
  assign unused_cmd_bits = ^host.cmd_word;

  for (genvar g = 0; g < SW_WIDTH; g++) begin : g_sw
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (1'b0)
    ) u_debounce (
      .clk_i   (clk_clk),
      .rst_ni  (reset_reset_n),
      .raw_i   (sw_raw[g]),
      .level_o (sw_level[g])
    );
  end

  // Buttons idle high (released), so their synchronizers reset to 1
  for (genvar g = 0; g < KEY_WIDTH; g++) begin : g_key
    debounce_bit #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .RESET_LEVEL     (1'b1)
    ) u_debounce (
      .clk_i   (clk_clk),
      .rst_ni  (reset_reset_n),
      .raw_i   (key_raw_n[g]),
      .level_o (key_level_n[g])
    );
  end

  assign key_level = ~key_level_n;
  assign cmd       = decode_cmd(host.cmd_word, cmd_prev_q);

  // Press detection, sticky flag and counter updates, command handling
  always_comb begin
    sw_out_d   = sw_level;
    key_out_d  = key_level;
    cmd_prev_d = cmd.level;
    // A press edge is a newly accepted level that the output has not shown yet
    press_edge = key_level & ~key_out_q;
    any_press  = |press_edge;
    clr_mask   = '0;
    if (cmd.strobe) begin
      clr_mask = cmd.clr_mask[KEY_WIDTH-1:0];
    end
    // Set wins over clear when both hit the same flag in one cycle
    sticky_d = (sticky_q & ~clr_mask) | press_edge;
    if (cmd.strobe && cmd.cnt_clr) begin
      cnt_d = any_press ? BTN_CNT_W'(1) : '0;
    end else begin
      cnt_d = cnt_q + BTN_CNT_W'(any_press);
    end
  end

  // Host-visible state registers
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      sw_out_q   <= '0;
      key_out_q  <= '0;
      sticky_q   <= '0;
      cnt_q      <= '0;
      cmd_prev_q <= 1'b0;
    end else begin
      sw_out_q   <= sw_out_d;
      key_out_q  <= key_out_d;
      sticky_q   <= sticky_d;
      cnt_q      <= cnt_d;
      cmd_prev_q <= cmd_prev_d;
    end
  end

  assign host.switch_word = WORD_W'(sw_out_q);
  assign host.button_word = pack_button_word(BTN_FIELD_W'(key_out_q),
                                             BTN_FIELD_W'(sticky_q),
                                             cmd_prev_q, cnt_q);

`ifdef PIO_COND_IRQ_EN
  logic irq_q, irq_d;

  // irq follows the sticky flags that will be visible alongside it
  always_comb begin
    irq_d = |(BTN_FIELD_W'(sticky_d) & cmd.irq_mask);
  end

  // Registered interrupt request
  always_ff @(posedge clk_clk) begin
    if (!reset_reset_n) begin
      irq_q <= 1'b0;
    end else begin
      irq_q <= irq_d;
    end
  end

  assign host.irq = irq_q;
`endif

endmodule

// File: tb/tb_pio_input_conditioner.sv
// Bench for pio_input_conditioner with DEBOUNCE_CYCLES=4: directed scenarios
// followed by random switch/button/command/reset activity, every cycle
// compared against a behavioural model of the switch and button words.
module tb_pio_input_conditioner;

  localparam int D  = 4;
  localparam int SW = 18;
  localparam int KW = 4;

  // ---------------- clock / reset ----------------
  logic          clk = 1'b0;
  logic          rst_n;
  logic [SW-1:0] sw_raw;
  logic [KW-1:0] key_raw_n;

  always #5 clk = ~clk;

  pio_input_conditioner_if host_if ();

  pio_input_conditioner #(
    .DEBOUNCE_CYCLES (D),
    .SW_WIDTH        (SW),
    .KEY_WIDTH       (KW)
  ) dut (
    .clk_clk       (clk),
    .reset_reset_n (rst_n),
    .sw_raw        (sw_raw),
    .key_raw_n     (key_raw_n),
    .host          (host_if)
  );

  // ---------------- checking ----------------
  int n_cmp = 0;
  int n_err = 0;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Accepted level of a bit changes once the last D synchronized samples all
  // disagree with it; the status words show the accepted state one cycle later.
  logic [SW-1:0] m_sw_pipe[$];
  logic [KW-1:0] m_key_pipe[$];   // active-high pressed
  logic [SW-1:0] m_sw_win[$];
  logic [KW-1:0] m_key_win[$];
  logic [SW-1:0] m_sw_acc, m_sw_out;
  logic [KW-1:0] m_key_acc, m_key_out, m_sticky, m_press;
  logic [7:0]    m_cnt;
  logic          m_ack, m_irq, m_strobe;
  logic [SW-1:0] m_sw_seen, m_sw_diff;
  logic [KW-1:0] m_key_seen, m_key_diff;
  logic [31:0]   m_bw;

  logic [63:0] exp_q[$];
  logic        exp_irq_q[$];

  always @(posedge clk) begin
    if (!rst_n) begin
      m_sw_pipe = {};  m_sw_pipe.push_back('0);  m_sw_pipe.push_back('0);
      m_key_pipe = {}; m_key_pipe.push_back('0); m_key_pipe.push_back('0);
      m_sw_win = {};   m_key_win = {};
      m_sw_acc = '0;   m_sw_out = '0;
      m_key_acc = '0;  m_key_out = '0;
      m_sticky = '0;   m_cnt = '0;
      m_ack = 1'b0;    m_irq = 1'b0;
    end else begin
      m_press  = m_key_acc & ~m_key_out;
      m_strobe = (host_if.cmd_word[31] != m_ack);
      if (m_strobe) m_sticky = m_sticky & ~host_if.cmd_word[7:4];
      m_sticky = m_sticky | m_press;
      if (m_strobe && host_if.cmd_word[8]) m_cnt = (m_press != 0) ? 8'd1 : 8'd0;
      else if (m_press != 0)               m_cnt = m_cnt + 8'd1;
      m_ack     = host_if.cmd_word[31];
      m_sw_out  = m_sw_acc;
      m_key_out = m_key_acc;
      m_irq     = |(m_sticky & host_if.cmd_word[12:9]);
      // synchronized samples: raw values from two clock edges ago
      m_sw_seen  = m_sw_pipe.pop_front();
      m_key_seen = m_key_pipe.pop_front();
      m_sw_pipe.push_back(sw_raw);
      m_key_pipe.push_back(~key_raw_n);
      m_sw_win.push_back(m_sw_seen);
      m_key_win.push_back(m_key_seen);
      if (m_sw_win.size() > D)  void'(m_sw_win.pop_front());
      if (m_key_win.size() > D) void'(m_key_win.pop_front());
      if (m_sw_win.size() == D) begin
        m_sw_diff = '1;
        foreach (m_sw_win[j]) m_sw_diff &= (m_sw_win[j] ^ m_sw_acc);
        m_sw_acc ^= m_sw_diff;
      end
      if (m_key_win.size() == D) begin
        m_key_diff = '1;
        foreach (m_key_win[j]) m_key_diff &= (m_key_win[j] ^ m_key_acc);
        m_key_acc ^= m_key_diff;
      end
    end
    m_bw = {8'h00, m_cnt, m_ack, 7'h00, m_sticky, m_key_out};
    exp_q.push_back({32'(m_sw_out), m_bw});
    exp_irq_q.push_back(m_irq);
  end

  // ---------------- scoreboard ----------------
  logic [63:0] exp_e;
  logic        exp_irq_e;

  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_e     = exp_q.pop_front();
      exp_irq_e = exp_irq_q.pop_front();
      check_val("switch_word", host_if.switch_word, exp_e[63:32]);
      check_val("button_word", host_if.button_word, exp_e[31:0]);
`ifdef PIO_COND_IRQ_EN
      check_val("irq", {31'd0, host_if.irq}, {31'd0, exp_irq_e});
`endif
    end
  end

  // ---------------- drivers ----------------
  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic press_release(input int k, input int hold);
    key_raw_n[k] = 1'b0;
    tick(hold);
    key_raw_n[k] = 1'b1;
    tick(hold);
  endtask

  int lat;

  initial begin
    rst_n = 1'b0;
    sw_raw = '0;
    key_raw_n = '1;
    host_if.cmd_word = 32'h0;
    tick(3);
    check_val("reset_sw", host_if.switch_word, 32'h0);
    check_val("reset_bw", host_if.button_word, 32'h0);
    rst_n = 1'b1;
    tick(2);

    // Stable switch change reaches the output D+3 cycles later
    sw_raw[0] = 1'b1;
    lat = 0;
    while (host_if.switch_word[0] !== 1'b1 && lat < 20) begin
      tick(1);
      lat++;
    end
    check_val("sw_latency", lat, 32'd7);

    // A pulse shorter than D cycles is ignored
    sw_raw[1] = 1'b1;
    tick(3);
    sw_raw[1] = 1'b0;
    tick(10);
    check_val("sw_glitch", host_if.switch_word, 32'h1);

    // Key 2 press: level, sticky flag and counter
    key_raw_n[2] = 1'b0;
    tick(10);
    check_val("key2_level",  {31'd0, host_if.button_word[2]}, 32'd1);
    check_val("key2_sticky", {31'd0, host_if.button_word[6]}, 32'd1);
    check_val("key2_cnt",    {24'd0, host_if.button_word[23:16]}, 32'd1);
    key_raw_n[2] = 1'b1;
    tick(10);
    check_val("key2_rel_level",  {31'd0, host_if.button_word[2]}, 32'd0);
    check_val("key2_rel_sticky", {31'd0, host_if.button_word[6]}, 32'd1);

    // Strobe clears flag 2 and acknowledges; holding the word clears nothing more
    host_if.cmd_word = 32'h8000_0040;
    tick(1);
    check_val("strobe_clr", {31'd0, host_if.button_word[6]}, 32'd0);
    check_val("strobe_ack", {31'd0, host_if.button_word[15]}, 32'd1);
    key_raw_n[2] = 1'b0;
    tick(10);
    key_raw_n[2] = 1'b1;
    tick(10);
    check_val("hold_no_clear", {31'd0, host_if.button_word[6]}, 32'd1);

    // Counter clear, then 256 presses wrap it back to zero
    host_if.cmd_word = 32'h0000_0100;
    tick(1);
    check_val("cnt_clear", {24'd0, host_if.button_word[23:16]}, 32'd0);
    for (int i = 0; i < 256; i++) press_release(1, 6);
    tick(10);
    check_val("cnt_wrap", {24'd0, host_if.button_word[23:16]}, 32'd0);

    // Counter clear strobe in the same cycle as a press edge leaves 1
    key_raw_n[3] = 1'b0;
    tick(6);
    host_if.cmd_word = 32'h8000_0100;
    tick(1);
    check_val("cnt_simul",  {24'd0, host_if.button_word[23:16]}, 32'd1);
    check_val("key3_level", {31'd0, host_if.button_word[3]}, 32'd1);
    key_raw_n[3] = 1'b1;
    tick(10);

    // Reset while key 0 is held; the press is re-accepted after release
    key_raw_n[0] = 1'b0;
    tick(10);
    rst_n = 1'b0;
    tick(1);
    check_val("rst_sw", host_if.switch_word, 32'h0);
    check_val("rst_bw", host_if.button_word, 32'h0);
    rst_n = 1'b1;
    lat = 0;
    while (host_if.button_word[0] !== 1'b1 && lat < 20) begin
      tick(1);
      lat++;
    end
    check_val("rst_key_latency", lat, 32'd7);
    check_val("rst_key_sticky", {31'd0, host_if.button_word[4]}, 32'd1);

`ifdef PIO_COND_IRQ_EN
    host_if.cmd_word = 32'h8000_0200;
    tick(1);
    check_val("irq_set", {31'd0, host_if.irq}, 32'd1);
    host_if.cmd_word = 32'h0000_0210;
    tick(1);
    check_val("irq_clr", {31'd0, host_if.irq}, 32'd0);
`endif

    key_raw_n[0] = 1'b1;
    tick(10);

    // Random activity on all inputs, occasional commands and resets
    for (int c = 0; c < 3000; c++) begin
      for (int i = 0; i < SW; i++)
        if ($urandom_range(0, 15) == 0) sw_raw[i] = ~sw_raw[i];
      for (int i = 0; i < KW; i++)
        if ($urandom_range(0, 7) == 0) key_raw_n[i] = ~key_raw_n[i];
      if ($urandom_range(0, 19) == 0) host_if.cmd_word = $urandom;
      rst_n = ($urandom_range(0, 399) == 0) ? 1'b0 : 1'b1;
      tick(1);
    end
    rst_n = 1'b1;
    tick(12);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/pio_input_conditioner.md
PIO_INPUT_CONDITIONER -- requirements
Module: pio_input_conditioner

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 50000: consecutive stable cycles needed to accept a new input level (1 ms at 50 MHz).
REQ-002 Parameter SW_WIDTH, default 18: number of slide switches.
REQ-003 Parameter KEY_WIDTH, default 4: number of push buttons, range 1..4.
REQ-004 clk_clk  in  1: single clock; all logic is on its rising edge.
REQ-005 reset_reset_n  in  1: reset, synchronous and active-low.
REQ-006 sw_raw  in  SW_WIDTH: asynchronous raw switch levels, 1 = on.
REQ-007 key_raw_n  in  KEY_WIDTH: asynchronous raw buttons, active-low (0 = pressed).
REQ-008 cmd_word  in  32: host command word from the hexport output PIO, on the clk_clk domain.
REQ-009 switch_word  out  32: drives switch_external_connection_export.
REQ-010 button_word  out  32: drives button_external_connection_export.

Function
REQ-011 Each raw bit SHALL pass through a 2-flop synchronizer before any other logic sees it.
REQ-012 Each synchronized bit SHALL have its own counter; the counter clears whenever the bit equals the accepted level, else increments.
REQ-013 The accepted level SHALL flip when the counter reaches DEBOUNCE_CYCLES-1 while the bit still differs; the counter then clears.
REQ-014 A raw change held stable SHALL reach the output register exactly DEBOUNCE_CYCLES+3 cycles later; any glitch shorter than DEBOUNCE_CYCLES cycles SHALL cause no change.
REQ-015 switch_word[SW_WIDTH-1:0] SHALL be the accepted switch levels; the upper bits SHALL be 0.
REQ-016 button_word[3:0] SHALL be the accepted key levels, active-high (1 = pressed); unused bits SHALL be 0.
REQ-017 button_word[7:4] SHALL be sticky press flags, set by a 0->1 transition of the matching accepted key level.
REQ-018 button_word[23:16] SHALL be an 8-bit press counter: +1 in each cycle with at least one press edge, wrapping 255->0.
REQ-019 button_word[15] SHALL echo the last accepted cmd_word[31] value, as the handshake acknowledge.
REQ-020 Other button_word bits SHALL be 0.
REQ-021 Command strobe is a change of cmd_word[31] from its registered previous value; one strobe is accepted per change, with no level sensitivity.
REQ-022 On a strobe, sticky flags whose mask bit in cmd_word[7:4] is 1 SHALL clear, and the counter SHALL clear if cmd_word[8] is 1; effect is visible 1 cycle after the change.
REQ-023 On a simultaneous strobe and press edge, set SHALL win for the flag, and the counter SHALL become 1 when it is being cleared, else it increments.
REQ-024 All outputs SHALL be registered; there are no combinational paths from inputs to outputs.

Reset
REQ-025 During reset, switch_word and button_word SHALL be 0.
REQ-026 During reset, all debounce counters SHALL be 0.
REQ-027 During reset, switch synchronizers SHALL load 0 and key synchronizers SHALL load 1 (released).
REQ-028 During reset, accepted levels SHALL be released/off and the previous cmd_word[31] register SHALL be 0.
REQ-029 Reset asserted mid-debounce SHALL discard the partial count.
REQ-030 After reset release, an input already held active SHALL be accepted DEBOUNCE_CYCLES+3 cycles later and SHALL produce a press edge.

Configuration
REQ-031 The macro PIO_COND_IRQ_EN, when defined, SHALL add the output irq (1 bit).
REQ-032 With PIO_COND_IRQ_EN, irq is registered and equals the OR of (button_word[7:4] AND cmd_word[12:9]); it is 0 in reset.
REQ-033 Without PIO_COND_IRQ_EN, the irq port and its logic SHALL be absent and cmd_word[12:9] SHALL be ignored.

Structure
REQ-034 Package pio_cond_pkg SHALL hold all bit-position constants: the strobe bit 31, clear mask 7:4, counter clear 8, irq mask 12:9, level 3:0, sticky 7:4, ack 15 and counter 23:16.
REQ-035 One sub-module, debounce_bit, SHALL contain the synchronizer, counter and accepted level for one bit, parameterized by DEBOUNCE_CYCLES and reset level.
REQ-036 debounce_bit SHALL be instantiated SW_WIDTH+KEY_WIDTH times.

Verification (DEBOUNCE_CYCLES=4)
REQ-037 Drive sw_raw[0] 0->1 and hold -> switch_word[0]=1 exactly 7 cycles later; a 3-cycle pulse on sw_raw[1] -> switch_word unchanged.
REQ-038 Press key_raw_n[2] (drive 0) for 10 cycles -> button_word[2]=1, button_word[6]=1 and counter=1; after release, [2]=0 and [6] stays 1.
REQ-039 Toggle cmd_word to 0x8000_0040 -> button_word[6]=0 and [15]=1 the next cycle; holding the word -> no further clears.
REQ-040 Make 256 press edges -> counter returns to 0x00; strobe with bit 8 in the same cycle as a press edge -> counter=1.
REQ-041 Assert reset for 1 cycle while key 0 is held -> outputs 0, then button_word[0]=1 and [4]=1 at 7 cycles.
REQ-042 With PIO_COND_IRQ_EN, irq mask 0x1 and a key 0 press -> irq=1; a clear strobe of bit 4 -> irq=0.
